// File: rtl/psram_write_coalescer.sv
// Buffers host byte writes and merges consecutive addresses into PSRAM write bursts; 1 cycle push->enable.
// Backpressure: in_ready drops when the FIFO is full; bursts advance only on psram_next_byte_needed.
module psram_write_coalescer #(
  parameter int DEPTH      = 16,
  parameter int MAX_BURST  = 32,
  parameter int PAGE_BITS  = 10,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [23:0]              in_address,
  input  logic [7:0]               in_data,
  output logic                     psram_enable,
  output logic                     psram_rw,
  output logic [23:0]              psram_address,
  output logic [7:0]               psram_data,
  input  logic                     psram_next_byte_needed,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef struct packed {
    logic [23:0] addr;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  entry_t          head;
  logic            push, pop;

  state_t          state_q, state_d;
  logic            enable_q, enable_d;
  logic [23:0]     address_q, address_d;
  logic [7:0]      data_q, data_d;
  logic [23:0]     last_addr_q, last_addr_d;
  logic [BCW-1:0]  burst_count_q, burst_count_d;
  logic [GCW-1:0]  gap_count_q, gap_count_d;

  logic [23:0]     next_addr;
  logic            fifo_nonempty, can_continue, gap_done;

  assign head          = mem_q[rd_ptr_q];
  assign in_ready      = (level_q != LW'(DEPTH));
  assign push          = in_valid && in_ready;
  assign fifo_nonempty = (level_q != '0);

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: in_address, data: in_data};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
    end
  end

  // Burst continues only on a strictly sequential address that stays inside the page and length cap.
  assign next_addr    = last_addr_q + 24'd1;
  assign can_continue = fifo_nonempty && (head.addr == next_addr) &&
                        (next_addr[PAGE_BITS-1:0] != '0) &&
                        (burst_count_q < BCW'(MAX_BURST));
  assign gap_done     = (int'(gap_count_q) + 1 >= GAP_CYCLES);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      enable_q      <= 1'b0;
      address_q     <= '0;
      data_q        <= '0;
      last_addr_q   <= '0;
      burst_count_q <= '0;
      gap_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      address_q     <= address_d;
      data_q        <= data_d;
      last_addr_q   <= last_addr_d;
      burst_count_q <= burst_count_d;
      gap_count_q   <= gap_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_nonempty) begin
          state_d = S_STREAM;
          pop     = 1'b1;
        end
      end
      S_STREAM: begin
        if (psram_next_byte_needed) begin
          if (can_continue) pop = 1'b1;
          else              state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    enable_d      = enable_q;
    address_d     = address_q;
    data_d        = data_q;
    last_addr_d   = last_addr_q;
    burst_count_d = burst_count_q;
    gap_count_d   = gap_count_q;
    case (state_q)
      S_IDLE: begin
        if (fifo_nonempty) begin
          address_d     = head.addr;
          data_d        = head.data;
          last_addr_d   = head.addr;
          burst_count_d = BCW'(1);
          enable_d      = 1'b1;
        end
      end
      S_STREAM: begin
        if (psram_next_byte_needed) begin
          if (can_continue) begin
            data_d        = head.data;
            last_addr_d   = next_addr;
            burst_count_d = burst_count_q + BCW'(1);
          end else begin
            enable_d    = 1'b0;
            gap_count_d = '0;
          end
        end
      end
      S_GAP: begin
        gap_count_d = gap_count_q + GCW'(1);
      end
      default: enable_d = 1'b0;
    endcase
  end

  assign psram_enable  = enable_q;
  assign psram_rw      = 1'b0;
  assign psram_address = address_q;
  assign psram_data    = data_q;
  assign fifo_level    = level_q;
  assign busy          = (state_q != S_IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_psram_write_coalescer.sv
// Directed bench for psram_write_coalescer: burst merging, breaks, backpressure and reset.
module tb_psram_write_coalescer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_address;
  logic [7:0]  in_data;
  logic        psram_enable;
  logic        psram_rw;
  logic [23:0] psram_address;
  logic [7:0]  psram_data;
  logic        psram_next_byte_needed;
  logic [4:0]  fifo_level;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [23:0] cap_addr;
  logic [7:0]  cap_q[$];
  bit          cap_to;
  bit          cap_addr_moved;

  logic [23:0] a1, a2;
  logic [7:0]  q1[$], q2[$];
  bit          to1, to2;
  int          pushed;

  always #5 clock = ~clock;

  psram_write_coalescer #(.DEPTH(16), .MAX_BURST(32), .PAGE_BITS(10), .GAP_CYCLES(2)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .in_address             (in_address),
    .in_data                (in_data),
    .psram_enable           (psram_enable),
    .psram_rw               (psram_rw),
    .psram_address          (psram_address),
    .psram_data             (psram_data),
    .psram_next_byte_needed (psram_next_byte_needed),
    .fifo_level             (fifo_level),
    .busy                   (busy)
  );

  task automatic push(input logic [23:0] a, input logic [7:0] d);
    in_valid = 1'b1; in_address = a; in_data = d;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Plays the controller: waits for a burst, pulses next_byte_needed every `interval` cycles.
  task automatic get_burst(input int interval);
    int n;
    n = 0; cap_q.delete(); cap_to = 0; cap_addr_moved = 0; cap_addr = '0;
    while (!psram_enable && n < 100) begin @(negedge clock); n++; end
    if (!psram_enable) begin cap_to = 1; return; end
    cap_addr = psram_address;
    while (psram_enable && cap_q.size() < 64) begin
      cap_q.push_back(psram_data);
      psram_next_byte_needed = 1'b1;
      @(negedge clock);
      psram_next_byte_needed = 1'b0;
      if (!psram_enable) break;
      if (psram_address !== cap_addr) cap_addr_moved = 1;
      repeat (interval - 1) @(negedge clock);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin @(negedge clock); n++; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_address = '0; in_data = '0;
    psram_next_byte_needed = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (psram_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", psram_enable); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (psram_address !== 24'h0) begin errors++; $display("FAIL reset_address: got %h want 0", psram_address); end
    checks++; if (psram_data !== 8'h0) begin errors++; $display("FAIL reset_data: got %h want 0", psram_data); end
    checks++; if (psram_rw !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b want 0", psram_rw); end
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    psram_next_byte_needed = 1'b1;
    @(negedge clock);
    psram_next_byte_needed = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (psram_enable !== 1'b0) begin errors++; $display("FAIL idle_enable: got %b want 0", psram_enable); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL idle_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_single_burst();
    logic [7:0] exp_d [4];
    exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 4; i++) push(24'h000100 + 24'(i), exp_d[i]);
    get_burst(8);
    checks++; if (cap_to !== 1'b0) begin errors++; $display("FAIL seq_timeout: no burst started"); end
    checks++; if (cap_addr !== 24'h000100) begin errors++; $display("FAIL seq_addr: got %h want 000100", cap_addr); end
    checks++; if (cap_q.size() != 4) begin errors++; $display("FAIL seq_len: got %0d want 4", cap_q.size()); end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_d[i]) begin errors++; $display("FAIL seq_data%0d: got %h want %h", i, cap_q[i], exp_d[i]); end
    end
    checks++; if (cap_addr_moved !== 1'b0) begin errors++; $display("FAIL seq_addr_stable: address changed mid-burst"); end
    checks++; if (psram_rw !== 1'b0) begin errors++; $display("FAIL seq_rw: got %b want 0", psram_rw); end
    checks++; if (psram_enable !== 1'b0) begin errors++; $display("FAIL seq_end_enable: got %b want 0", psram_enable); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL seq_gap1_busy: got %b want 1", busy); end
    @(negedge clock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL seq_gap2_busy: got %b want 1", busy); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL seq_after_gap_busy: got %b want 0", busy); end
  endtask

  task automatic test_discontinuity();
    int low;
    push(24'h000010, 8'hB0); push(24'h000011, 8'hB1); push(24'h000200, 8'hB2);
    get_burst(4);
    checks++; if (cap_addr !== 24'h000010 || cap_q.size() != 2) begin errors++; $display("FAIL disc_b1: got addr %h len %0d want 000010 len 2", cap_addr, cap_q.size()); end
    checks++; if (cap_q.size() != 2 || cap_q[0] !== 8'hB0 || cap_q[1] !== 8'hB1) begin errors++; $display("FAIL disc_b1_data: got len %0d want B0 B1", cap_q.size()); end
    low = 0;
    while (!psram_enable && low < 50) begin low++; @(negedge clock); end
    checks++; if (low != 3) begin errors++; $display("FAIL disc_gap: got %0d low cycles want 3", low); end
    get_burst(4);
    checks++; if (cap_addr !== 24'h000200 || cap_q.size() != 1) begin errors++; $display("FAIL disc_b2: got addr %h len %0d want 000200 len 1", cap_addr, cap_q.size()); end
    checks++; if (cap_q.size() != 1 || cap_q[0] !== 8'hB2) begin errors++; $display("FAIL disc_b2_data: got len %0d want B2", cap_q.size()); end
    wait_idle();
  endtask

  task automatic test_page_break();
    push(24'h0003FE, 8'hC0); push(24'h0003FF, 8'hC1); push(24'h000400, 8'hC2);
    get_burst(3);
    checks++; if (cap_addr !== 24'h0003FE || cap_q.size() != 2) begin errors++; $display("FAIL page_b1: got addr %h len %0d want 0003FE len 2", cap_addr, cap_q.size()); end
    checks++; if (cap_q.size() != 2 || cap_q[0] !== 8'hC0 || cap_q[1] !== 8'hC1) begin errors++; $display("FAIL page_b1_data: got len %0d want C0 C1", cap_q.size()); end
    get_burst(3);
    checks++; if (cap_addr !== 24'h000400 || cap_q.size() != 1) begin errors++; $display("FAIL page_b2: got addr %h len %0d want 000400 len 1", cap_addr, cap_q.size()); end
    checks++; if (cap_q.size() != 1 || cap_q[0] !== 8'hC2) begin errors++; $display("FAIL page_b2_data: got len %0d want C2", cap_q.size()); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int bad;
    pushed = 0;
    while (in_ready && pushed < 40) begin
      in_valid = 1'b1; in_address = 24'(pushed); in_data = 8'(pushed);
      @(negedge clock);
      pushed++;
    end
    checks++; if (pushed != 17) begin errors++; $display("FAIL bp_pushed: got %0d want 17", pushed); end
    checks++; if (fifo_level !== 5'd16 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got level %0d ready %b want 16 0", fifo_level, in_ready); end
    in_valid = 1'b1; in_address = 24'(pushed); in_data = 8'(pushed);
    repeat (3) @(negedge clock);
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL bp_full_hold: got level %0d want 16", fifo_level); end
    fork
      begin
        int g;
        logic rdy;
        g = 0;
        while (pushed < 40 && g < 3000) begin
          in_valid = 1'b1; in_address = 24'(pushed); in_data = 8'(pushed);
          rdy = in_ready;
          @(negedge clock);
          if (rdy) pushed++;
          g++;
        end
        in_valid = 1'b0;
      end
      begin
        get_burst(2); a1 = cap_addr; q1 = cap_q; to1 = cap_to;
        get_burst(2); a2 = cap_addr; q2 = cap_q; to2 = cap_to;
      end
    join
    checks++; if (to1 || a1 !== 24'h0 || q1.size() != 32) begin errors++; $display("FAIL bp_b1: got addr %h len %0d want 000000 len 32", a1, q1.size()); end
    bad = 0;
    for (int i = 0; i < q1.size(); i++) if (q1[i] !== 8'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_b1_data: got %0d wrong bytes want 0", bad); end
    checks++; if (to2 || a2 !== 24'd32 || q2.size() != 8) begin errors++; $display("FAIL bp_b2: got addr %h len %0d want 000020 len 8", a2, q2.size()); end
    bad = 0;
    for (int i = 0; i < q2.size(); i++) if (q2[i] !== 8'(32 + i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_b2_data: got %0d wrong bytes want 0", bad); end
    wait_idle();
    checks++; if (fifo_level !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL bp_drained: got level %0d busy %b want 0 0", fifo_level, busy); end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    for (int i = 0; i < 5; i++) push(24'h000050 + 24'(i), 8'hD0 + 8'(i));
    n = 0;
    while (!psram_enable && n < 50) begin @(negedge clock); n++; end
    repeat (2) begin
      psram_next_byte_needed = 1'b1; @(negedge clock);
      psram_next_byte_needed = 1'b0; @(negedge clock);
    end
    checks++; if (psram_enable !== 1'b1 || psram_data !== 8'hD2) begin errors++; $display("FAIL rst_third_byte: got en %b data %h want 1 D2", psram_enable, psram_data); end
    reset_n = 1'b0;
    #1;
    checks++; if (psram_enable !== 1'b0) begin errors++; $display("FAIL rst_async_enable: got %b want 0", psram_enable); end
    checks++; if (fifo_level !== 5'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_state: got level %0d busy %b ready %b want 0 0 1", fifo_level, busy, in_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    push(24'h000005, 8'hE5);
    get_burst(3);
    checks++; if (cap_to || cap_addr !== 24'h000005 || cap_q.size() != 1) begin errors++; $display("FAIL rst_fresh: got addr %h len %0d want 000005 len 1", cap_addr, cap_q.size()); end
    checks++; if (cap_q.size() != 1 || cap_q[0] !== 8'hE5) begin errors++; $display("FAIL rst_fresh_data: got len %0d want E5", cap_q.size()); end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_discontinuity();
    test_page_break();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
